// File: rtl/dsc_pkg.sv
// ----------------------------------------------------------------------------
// dsc_pkg: shared state encoding and width helpers for the DSC datapath.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dsc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } dsc_state_e;

  function automatic int stream_len(input int data_width, input int num_inputs);
    return 1 << (data_width * num_inputs);
  endfunction

  function automatic int out_width(input int data_width, input int num_inputs);
    return data_width * num_inputs + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dsc_ones_counter.sv
// ----------------------------------------------------------------------------
// dsc_ones_counter: enabled, clearable accumulator of single-bit addends.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dsc_ones_counter #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             add_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + WIDTH'(add_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/dsc_stream_decoder.sv
// ----------------------------------------------------------------------------
// dsc_stream_decoder: counts ones over a STREAM_LEN-beat stochastic frame.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dsc_stream_decoder
  import dsc_pkg::*;
#(
  parameter  int DATA_WIDTH = 5,
  parameter  int NUM_INPUTS = 2,
  localparam int OUT_WIDTH  = out_width(DATA_WIDTH, NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  bit_valid,
  input  logic                  bit_in,
  output logic [OUT_WIDTH-1:0]  bin_data_out,
  output logic [DATA_WIDTH-1:0] bin_data_scaled,
  output logic                  busy,
  output logic                  done
);

  localparam int BEAT_W     = DATA_WIDTH * NUM_INPUTS;
  localparam int STREAM_LEN = stream_len(DATA_WIDTH, NUM_INPUTS);
  localparam int SHIFT      = DATA_WIDTH * (NUM_INPUTS - 1);

  dsc_state_e            state_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [OUT_WIDTH-1:0]  out_q;
  logic [DATA_WIDTH-1:0] scaled_q;
  logic                  done_q;

  logic                  frame_start;
  logic                  beat_accept;
  logic                  last_beat;
  logic [OUT_WIDTH-1:0]  ones_count;
  logic [OUT_WIDTH-1:0]  count_d;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH-1:0] scaled_d;

  assign frame_start = en && (state_q == ST_IDLE) && start;
  assign beat_accept = en && (state_q == ST_ACCUM) && bit_valid;
  assign last_beat   = beat_accept && (beat_q == BEAT_W'(STREAM_LEN - 1));

  dsc_ones_counter #(
    .WIDTH (OUT_WIDTH)
  ) u_ones_counter (
    .clk     (clk),
    .rst     (rst),
    .en_i    (beat_accept),
    .clr_i   (frame_start),
    .add_i   (bit_in),
    .count_o (ones_count)
  );

  // The final beat is not yet in the accumulator, so fold it in here.
  assign count_d = ones_count + OUT_WIDTH'(bit_in);
  assign shifted = count_d[OUT_WIDTH-1:SHIFT];

  // Only a full-ones frame sets the top bit; clamp it to the operand range.
  always_comb begin
    scaled_d = shifted[DATA_WIDTH-1:0];
    if (shifted[DATA_WIDTH]) begin
      scaled_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      out_q    <= '0;
      scaled_q <= '0;
      done_q   <= 1'b0;
    end else if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            beat_q  <= '0;
            state_q <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (bit_valid) begin
            beat_q <= beat_q + BEAT_W'(1);
            if (last_beat) begin
              out_q    <= count_d;
              scaled_q <= scaled_d;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bin_data_out    = out_q;
  assign bin_data_scaled = scaled_q;
  assign busy            = (state_q == ST_ACCUM);
  // A DONE cycle frozen by en=0 must not show the pulse until it can advance.
  assign done            = done_q && en;

endmodule

`default_nettype wire

// File: tb/tb_dsc_stream_decoder.sv
// ----------------------------------------------------------------------------
// tb_dsc_stream_decoder: directed and randomized frames against a count model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dsc_stream_decoder;

  localparam int DW = 3;
  localparam int NI = 2;
  localparam int SL = 64;
  localparam int OW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          start;
  logic          bit_valid;
  logic          bit_in;
  logic [OW-1:0] bin_data_out;
  logic [DW-1:0] bin_data_scaled;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;
  int prev_cnt = 0;
  bit fb[SL];

  always #5 clk = ~clk;

  dsc_stream_decoder #(
    .DATA_WIDTH (DW),
    .NUM_INPUTS (NI)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .start           (start),
    .bit_valid       (bit_valid),
    .bit_in          (bit_in),
    .bin_data_out    (bin_data_out),
    .bin_data_scaled (bin_data_scaled),
    .busy            (busy),
    .done            (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scaled result: count divided by the per-operand step, clamped to operand max.
  function automatic int ref_scaled(input int cnt);
    int q;
    q = cnt / (SL / (1 << DW));
    return (q > (1 << DW) - 1) ? (1 << DW) - 1 : q;
  endfunction

  task automatic run_frame(input string name, input bit bits[SL], input int gaps,
                           input int en_low_at, input int restart_at, input int rst_at);
    int exp_cnt;
    int early_done;
    int g;
    exp_cnt = 0;
    early_done = 0;
    for (int i = 0; i < SL; i++) exp_cnt += int'(bits[i]);

    start = 1'b1; bit_valid = 1'b0; tick(); start = 1'b0;
    chk({name, ":busy_start"}, busy, 1);

    for (int i = 0; i < SL; i++) begin
      if (i == rst_at) begin
        rst = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; tick();
        rst = 1'b0; bit_valid = 1'b0;
        chk({name, ":rst_out"}, bin_data_out, 0);
        chk({name, ":rst_scaled"}, bin_data_scaled, 0);
        chk({name, ":rst_busy"}, busy, 0);
        chk({name, ":rst_done"}, done, 0);
        prev_cnt = 0;
        return;
      end
      g = (gaps != 0) ? $urandom_range(3) : 0;
      repeat (g) begin
        bit_valid = 1'b0; bit_in = 1'($urandom_range(1)); tick();
        if (done) early_done++;
      end
      if (i == en_low_at) begin
        en = 1'b0; bit_valid = 1'b1; bit_in = 1'b1; start = 1'b1;
        repeat (10) begin
          tick();
          if (done) early_done++;
        end
        chk({name, ":frozen_busy"}, busy, 1);
        en = 1'b1; start = 1'b0;
      end
      if (i == SL / 2) begin
        chk({name, ":held_out"}, bin_data_out, prev_cnt);
        chk({name, ":held_scaled"}, bin_data_scaled, ref_scaled(prev_cnt));
      end
      start = (i == restart_at);
      bit_valid = 1'b1; bit_in = bits[i]; tick();
      start = 1'b0; bit_valid = 1'b0;
      if (i < SL - 1 && done) early_done++;
    end

    chk({name, ":early_done"}, early_done, 0);
    chk({name, ":done"}, done, 1);
    chk({name, ":out"}, bin_data_out, exp_cnt);
    chk({name, ":scaled"}, bin_data_scaled, ref_scaled(exp_cnt));
    chk({name, ":busy_end"}, busy, 0);
    prev_cnt = exp_cnt;

    // A beat offered during the DONE cycle must be ignored.
    bit_valid = 1'b1; bit_in = 1'b1; tick(); bit_valid = 1'b0;
    chk({name, ":done_one_cycle"}, done, 0);
    chk({name, ":out_held"}, bin_data_out, exp_cnt);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b1; bit_valid = 1'b0; bit_in = 1'b0;
    tick(); tick();
    chk("reset_out", bin_data_out, 0);
    chk("reset_scaled", bin_data_scaled, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    en = 1'b1; start = 1'b1; tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_over_start", busy, 0);

    bit_valid = 1'b1; bit_in = 1'b1;
    repeat (3) tick();
    bit_valid = 1'b0;
    chk("idle_beats_busy", busy, 0);
    chk("idle_beats_done", done, 0);

    for (int i = 0; i < SL; i++) fb[i] = 1'b1;
    run_frame("all_ones", fb, 0, -1, -1, -1);

    for (int i = 0; i < SL; i++) fb[i] = (i % 2 == 0);
    run_frame("alternating", fb, 0, -1, -1, -1);

    for (int i = 0; i < SL; i++) fb[i] = 1'b0;
    run_frame("zeros_gaps_en", fb, 1, 20, -1, -1);

    for (int i = 0; i < SL; i++) fb[i] = 1'b1;
    run_frame("rst_mid", fb, 0, -1, -1, 30);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_done", done, 0);
    end

    for (int i = 0; i < SL; i++) fb[i] = (i < 5);
    run_frame("five_ones", fb, 0, -1, -1, -1);

    for (int i = 0; i < SL; i++) fb[i] = 1'($urandom_range(1));
    run_frame("restart_ign", fb, 1, -1, 10, -1);

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < SL; i++) fb[i] = 1'($urandom_range(1));
      run_frame("back_to_back", fb, f % 2, -1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
